// File: rtl/pulse_period_meter.sv
// Measures high time and rising-to-rising period of an asynchronous pulse train.
// Results are 8-bit clk-cycle counts; periods beyond 255 cycles raise a sticky overflow flag.
`timescale 1ns/1ps
module pulse_period_meter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [7:0] width_meas,
  output logic [7:0] period_meas,
  output logic       meas_valid,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t     state, state_nxt;
  logic       s1, s2, s3;
  logic [7:0] width_cnt, width_cnt_nxt;
  logic [7:0] period_cnt, period_cnt_nxt;
  logic [7:0] width_hold, width_hold_nxt;
  logic [7:0] width_meas_nxt, period_meas_nxt;
  logic       meas_valid_nxt, overflow_nxt;
  logic       rise, fall, at_limit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign at_limit = (period_cnt == 8'd255);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      width_cnt   <= 8'd0;
      period_cnt  <= 8'd0;
      width_hold  <= 8'd0;
      width_meas  <= 8'd0;
      period_meas <= 8'd0;
      meas_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      width_cnt   <= width_cnt_nxt;
      period_cnt  <= period_cnt_nxt;
      width_hold  <= width_hold_nxt;
      width_meas  <= width_meas_nxt;
      period_meas <= period_meas_nxt;
      meas_valid  <= meas_valid_nxt;
      overflow    <= overflow_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt       = state;
    width_cnt_nxt   = width_cnt;
    period_cnt_nxt  = period_cnt;
    width_hold_nxt  = width_hold;
    width_meas_nxt  = width_meas;
    period_meas_nxt = period_meas;
    meas_valid_nxt  = 1'b0;
    overflow_nxt    = overflow;

    if (!enable) begin
      // Disable beats everything, including a coincident closing edge.
      state_nxt      = IDLE;
      width_cnt_nxt  = 8'd0;
      period_cnt_nxt = 8'd0;
      overflow_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: state_nxt = ARM;

        ARM: begin
          if (rise) begin
            state_nxt      = HIGH;
            width_cnt_nxt  = 8'd1;
            period_cnt_nxt = 8'd1;
          end
        end

        HIGH: begin
          // width_cnt never exceeds period_cnt, so the period limit covers both.
          if (at_limit) begin
            state_nxt      = ARM;
            width_cnt_nxt  = 8'd0;
            period_cnt_nxt = 8'd0;
            overflow_nxt   = 1'b1;
          end else if (fall) begin
            state_nxt      = LOW;
            width_hold_nxt = width_cnt;
            period_cnt_nxt = period_cnt + 8'd1;
          end else begin
            width_cnt_nxt  = width_cnt + 8'd1;
            period_cnt_nxt = period_cnt + 8'd1;
          end
        end

        LOW: begin
          if (rise) begin
            state_nxt       = HIGH;
            width_meas_nxt  = width_hold;
            period_meas_nxt = period_cnt;
            meas_valid_nxt  = 1'b1;
            width_cnt_nxt   = 8'd1;
            period_cnt_nxt  = 8'd1;
          end else if (at_limit) begin
            state_nxt      = ARM;
            width_cnt_nxt  = 8'd0;
            period_cnt_nxt = 8'd0;
            overflow_nxt   = 1'b1;
          end else begin
            period_cnt_nxt = period_cnt + 8'd1;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: each closing rising edge driven queues
// the expected width/period and the cycle the strobe is due; a monitor pops on meas_valid.
`timescale 1ns/1ps
module tb_pulse_period_meter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pulse_in;
  logic [7:0] width_meas;
  logic [7:0] period_meas;
  logic       meas_valid;
  logic       overflow;

  pulse_period_meter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pulse_in   (pulse_in),
    .width_meas (width_meas),
    .period_meas(period_meas),
    .meas_valid (meas_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic [7:0] p;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   prev_h, prev_l;
  bit   have_prev = 0;
  logic [7:0] last_w, last_p;

  always @(posedge clk) cyc = cyc + 1;

  // Strobe monitor: every meas_valid must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].due) begin
      total++;
      bad++;
      $display("FAIL missing_valid: no strobe by cycle %0d, required one at %0d (w=%0d p=%0d)",
               cyc, sb[0].due, sb[0].w, sb[0].p);
      void'(sb.pop_front());
    end
    if (meas_valid === 1'b1) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_valid: got strobe w=%0d p=%0d at cycle %0d, required none",
                 width_meas, period_meas, cyc);
      end else begin
        e = sb.pop_front();
        if (width_meas !== e.w || period_meas !== e.p || cyc !== e.due) begin
          bad++;
          $display("FAIL meas: got w=%0d p=%0d cycle=%0d, required w=%0d p=%0d cycle=%0d",
                   width_meas, period_meas, cyc, e.w, e.p, e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after a step, just before driving a rising edge.
  task automatic push_expect();
    if (have_prev) begin
      exp_t e;
      e.w   = 8'(prev_h);
      e.p   = 8'(prev_h + prev_l);
      e.due = cyc + 3;
      sb.push_back(e);
      last_w = e.w;
      last_p = e.p;
    end
  endtask

  task automatic pulse(input int h, input int l);
    push_expect();
    prev_h    = h;
    prev_l    = l;
    have_prev = 1;
    pulse_in  = 1'b1;
    repeat (h) step();
    pulse_in = 1'b0;
    repeat (l) step();
  endtask

  task automatic expect_outputs(input string name, input logic [7:0] w, input logic [7:0] p,
                                input logic v, input logic o);
    total++;
    if (width_meas !== w || period_meas !== p || meas_valid !== v || overflow !== o) begin
      bad++;
      $display("FAIL %s: got w=%0d p=%0d v=%b o=%b, required w=%0d p=%0d v=%b o=%b",
               name, width_meas, period_meas, meas_valid, overflow, w, p, v, o);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    enable   = 1'b0;
    pulse_in = 1'b0;
    #2;
    expect_outputs("reset_state", 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    expect_outputs("after_release", 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    enable = 1'b1;
    repeat (3) step();
    repeat (4) pulse(3, 7);
  endtask

  task automatic test_switch();
    repeat (3) pulse(5, 10);
  endtask

  task automatic test_min_pulse();
    repeat (6) pulse(1, 1);
  endtask

  task automatic test_max_period();
    repeat (2) pulse(5, 250);
  endtask

  task automatic test_overflow();
    int k;
    push_expect();
    k         = cyc;
    have_prev = 0;
    pulse_in  = 1'b1;
    repeat (2) step();
    pulse_in = 1'b0;
    while (cyc < k + 257) step();
    @(negedge clk);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_early: got %b at period 255, required 0", overflow);
    end
    step();
    @(negedge clk);
    expect_outputs("overflow_set", 8'd5, 8'd255, 1'b0, 1'b1);
    while (cyc < k + 305) step();
    expect_outputs("overflow_sticky", 8'd5, 8'd255, 1'b0, 1'b1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    expect_outputs("overflow_cleared", 8'd5, 8'd255, 1'b0, 1'b0);
    repeat (2) step();
  endtask

  task automatic test_enable_mid();
    repeat (3) pulse(4, 6);
    push_expect();
    pulse_in = 1'b1;
    repeat (4) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (2) step();
    pulse_in  = 1'b0;
    have_prev = 0;
    repeat (6) step();
    expect_outputs("hold_after_disable", last_w, last_p, 1'b0, 1'b0);
    pulse(4, 6);
    expect_outputs("hold_after_first_rise", last_w, last_p, 1'b0, 1'b0);
    pulse(4, 6);
  endtask

  task automatic test_back_to_back_enable_race();
    have_prev = 0;
    pulse_in  = 1'b1;
    repeat (2) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (2) step();
    pulse_in = 1'b0;
    repeat (6) step();
    expect_outputs("enable_wins", last_w, last_p, 1'b0, 1'b0);
    repeat (3) pulse(3, 3);
  endtask

  task automatic test_reset_mid();
    repeat (3) pulse(2, 3);
    push_expect();
    pulse_in = 1'b1;
    repeat (4) step();
    #1 reset = 1'b0;
    #1 expect_outputs("async_reset_mid_high", 8'd0, 8'd0, 1'b0, 1'b0);
    sb.delete();
    have_prev = 0;
    pulse_in  = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    repeat (3) pulse(2, 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_switch();
    test_min_pulse();
    test_max_period();
    test_overflow();
    test_enable_mid();
    test_back_to_back_enable_race();
    test_reset_mid();
    repeat (10) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected strobes outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Port clk, input, 1: single clock; all state on rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-low; reset==0 forces reset state immediately.
REQ-003 Port enable, input, 1: 1 = measure, 0 = idle.
REQ-004 Port pulse_in, input, 1: pulse train from the programmable pulse generator's pulse_out; treated as asynchronous.
REQ-005 Port width_meas, output, 8: high time of the last complete pulse, in clk cycles.
REQ-006 Port period_meas, output, 8: rising-to-rising period of the last complete pulse, in clk cycles.
REQ-007 Port meas_valid, output, 1: one-cycle strobe; width_meas/period_meas updated this cycle.
REQ-008 Port overflow, output, 1: sticky flag; a period exceeded 255 cycles.
REQ-009 No parameters; all counters and outputs 8 bits.

Function
REQ-010 pulse_in shall pass a 2-flop synchronizer (s1, s2) plus a previous-value flop (s3).
REQ-011 Rising edge: s2=1 & s3=0. Falling edge: s2=0 & s3=1.
REQ-012 FSM states: IDLE, ARM, HIGH, LOW.
REQ-013 Any state with enable=0 -> IDLE next cycle; counters cleared; meas_valid=0; width_meas/period_meas hold; overflow cleared.
REQ-014 IDLE with enable=1 -> ARM; no measurement output in ARM.
REQ-015 ARM on rising edge -> HIGH; width_cnt=1; period_cnt=1; no meas_valid.
REQ-016 HIGH: width_cnt and period_cnt +1 per cycle; on falling edge, width_hold<=width_cnt, period_cnt+1, -> LOW.
REQ-017 LOW: period_cnt +1 per cycle; on rising edge, width_meas<=width_hold, period_meas<=period_cnt, meas_valid=1, width_cnt=1, period_cnt=1, -> HIGH.
REQ-018 A measurement is emitted only on a rising edge that closes a full HIGH+LOW cycle.
REQ-019 Bench convention: pulse high H cycles, low L cycles at clk rate. Result: width_meas=H, period_meas=H+L.
REQ-020 Minimum legal pulse is H=1, L=1 and shall measure as 1/2.
REQ-021 Latency: meas_valid asserts on the 2nd clk edge after the edge that first samples the closing rising edge of pulse_in (synchronizer delay), registered.
REQ-022 If period_cnt=255 and another increment is due (HIGH or LOW), then:
  - overflow<=1;
  - no meas_valid;
  - counters cleared;
  - FSM -> ARM.
REQ-023 The HIGH-state width check is identical to REQ-022 and is subsumed by it, since width_cnt<=period_cnt.
REQ-024 overflow stays 1 until reset or enable=0; new measurements still proceed while it is set.
REQ-025 Simultaneous enable deassert and closing rising edge: enable wins; no meas_valid.
REQ-026 Outputs shall be registered; no combinational path from pulse_in to any output.

Reset
REQ-027 reset=0: state IDLE; s1/s2/s3=0; counters=0; width_hold=0; width_meas=0; period_meas=0; meas_valid=0; overflow=0.
REQ-028 Reset mid-measurement discards the partial measurement. After release the block restarts from IDLE/ARM and needs two rising edges before the first meas_valid.

Verification
REQ-029 reset=0 asserted mid-HIGH while counting -> all outputs 0 immediately, without waiting for a clk edge.
REQ-030 enable=1; pulse_in 3 high / 7 low, repeated -> first meas_valid at the 2nd rising edge, width_meas=3, period_meas=10; then meas_valid every 10 cycles.
REQ-031 Switch train to 5 high / 10 low at a rising edge -> next valid reads 5/15, then every 15 cycles.
REQ-032 After one valid, hold pulse_in low 300 cycles -> overflow=1 once period_cnt passes 255, no meas_valid; enable=0 for one cycle -> overflow=0.
REQ-033 Toggle pulse_in every cycle (1/1) -> width_meas=1, period_meas=2, meas_valid every 2 cycles.
REQ-034 enable=0 mid-HIGH, re-enable -> no meas_valid until two rising edges have occurred; held outputs unchanged meanwhile.
